// File: rtl/carry_incr_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder/incrementer: one SLICE-bit carry slice per clock, LSB slice first.
// Optional macro CIS_EARLY_DONE_EN finishes early once the remaining slices cannot change the result.
module carry_incr_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   slice_sum;
  logic             c_msb;
  logic             last_slice;
  logic             early_done;

  assign a_sl       = a_q[cnt*SLICE +: SLICE];
  assign b_sl       = b_q[cnt*SLICE +: SLICE];
  assign slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry};
  // Carry into the slice MSB is recovered from its operand bits and sum bit
  assign c_msb      = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_sum[SLICE-1];
  assign last_slice = (cnt == CW'(NSLICE - 1));

`ifdef CIS_EARLY_DONE_EN
  logic [WIDTH-1:0] upper_ops;
  assign upper_ops  = (a_q | b_q) >> ((int'(cnt) + 1) * SLICE);
  assign early_done = !last_slice && !slice_sum[SLICE] && (upper_ops == '0);
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_slice || early_done) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= op_inc ? '0 : b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          sum[cnt*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
          carry                   <= slice_sum[SLICE];
          if (last_slice) begin
            cout <= slice_sum[SLICE];
            ovf  <= c_msb ^ slice_sum[SLICE];
            cnt  <= '0;
          end else if (early_done) begin
            // Upper sum slices are already zero from acceptance; zero MSB operands and carry give no overflow
            cout <= 1'b0;
            ovf  <= 1'b0;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_incr_seq_ctrl.sv
// Self-checking bench for carry_incr_seq_ctrl: directed cases plus randomized ops against an arithmetic model.
// Define CIS_EARLY_DONE_EN for both bench and RTL to exercise the early-done build.
module tb_carry_incr_seq_ctrl;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             op_inc = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  carry_incr_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_inc(op_inc),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic for the result, signed range test for overflow
  function automatic void ref_model(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                                    input logic inc, output logic [31:0] s, output logic co,
                                    output logic ov, output int lat);
    logic [31:0]     bb;
    longint unsigned t;
    longint          sa, sb, sv;
    bb = inc ? 32'd0 : bi;
    t  = longint'(ai) + longint'(bb) + (ci ? 64'd1 : 64'd0);
    s  = t[31:0];
    co = t[32];
    sa = $signed(ai);
    sb = $signed(bb);
    sv = sa + sb;
    if (ci) sv = sv + 1;
    ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    lat = NSLICE;
`ifdef CIS_EARLY_DONE_EN
    for (int k = 0; k < NSLICE - 1; k++) begin
      int bits;
      longint unsigned m, low;
      bits = (k + 1) * SLICE;
      m    = (64'd1 << bits) - 64'd1;
      low  = (longint'(ai) & m) + (longint'(bb) & m) + (ci ? 64'd1 : 64'd0);
      if (((longint'(ai) >> bits) == 0) && ((longint'(bb) >> bits) == 0) && ((low >> bits) == 0)) begin
        lat = k + 1;
        break;
      end
    end
`endif
  endfunction

  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic ci, input logic inc,
                        output logic [31:0] s, output logic co, output logic ov, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ai; b = bi; cin = ci; op_inc = inc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); op_inc = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s = sum; co = cout; ov = ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (sum !== 32'd0) begin errors++; $display("[TB] FAIL reset_sum got %h expected 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b expected 0", ovf); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0010, 32'h0100_0000};
    logic [31:0] tb [6] = '{32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 32'h8000_0000, 32'h0000_0020, 32'h0000_0000};
    logic        tc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ti [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] es [6] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0030, 32'h0100_0000};
    logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] s, ms;
      logic co, ov, mc, mo;
      int lat, mlat;
      ref_model(ta[i], tb[i], tc[i], ti[i], ms, mc, mo, mlat);
      run_op(ta[i], tb[i], tc[i], ti[i], s, co, ov, lat);
      checks++; if (s !== es[i]) begin errors++; $display("[TB] FAIL directed%0d_sum got %h expected %h", i, s, es[i]); end
      checks++; if (co !== ec[i]) begin errors++; $display("[TB] FAIL directed%0d_cout got %b expected %b", i, co, ec[i]); end
      checks++; if (ov !== eo[i]) begin errors++; $display("[TB] FAIL directed%0d_ovf got %b expected %b", i, ov, eo[i]); end
      checks++; if (lat != mlat) begin errors++; $display("[TB] FAIL directed%0d_latency got %0d expected %0d", i, lat, mlat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] masks [4] = '{32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb, s, ms;
      logic rc, ri, co, ov, mc, mo;
      int lat, mlat;
      ra = $urandom & masks[$urandom_range(0, 3)];
      rb = $urandom & masks[$urandom_range(0, 3)];
      rc = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      ref_model(ra, rb, rc, ri, ms, mc, mo, mlat);
      run_op(ra, rb, rc, ri, s, co, ov, lat);
      checks++; if (s !== ms) begin errors++; $display("[TB] FAIL random%0d_sum got %h expected %h", i, s, ms); end
      checks++; if (co !== mc) begin errors++; $display("[TB] FAIL random%0d_cout got %b expected %b", i, co, mc); end
      checks++; if (ov !== mo) begin errors++; $display("[TB] FAIL random%0d_ovf got %b expected %b", i, ov, mo); end
      checks++; if (lat != mlat) begin errors++; $display("[TB] FAIL random%0d_latency got %0d expected %0d", i, lat, mlat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ms;
    logic mc, mo;
    int mlat, n;
    ref_model(32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0, ms, mc, mo, mlat);
    a = 32'h89AB_CDEF; b = 32'h7654_3210; cin = 1'b1; op_inc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_run_in_ready got %b expected 0", in_ready); end
      in_valid = ~in_valid; a = $urandom; b = $urandom; cin = ~cin; op_inc = ~op_inc;
      @(negedge clk);
      n++;
    end
    checks++; if (n != mlat) begin errors++; $display("[TB] FAIL bp_latency got %0d expected %0d", n, mlat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid got %b expected 1", out_valid); end
      checks++; if (sum !== ms) begin errors++; $display("[TB] FAIL bp_hold_sum got %h expected %h", sum, ms); end
      checks++; if (cout !== mc) begin errors++; $display("[TB] FAIL bp_hold_cout got %b expected %b", cout, mc); end
      checks++; if (ovf !== mo) begin errors++; $display("[TB] FAIL bp_hold_ovf got %b expected %b", ovf, mo); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_in_ready got %b expected 0", in_ready); end
      in_valid = ~in_valid; a = $urandom; b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_handshake_in_ready got %b expected 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_not_queued got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    logic co, ov;
    int lat;
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; op_inc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got %b expected 0", out_valid); end
    checks++; if (sum !== 32'd0) begin errors++; $display("[TB] FAIL midrst_sum got %h expected 0", sum); end
    run_op(32'd5, 32'd3, 1'b0, 1'b0, s, co, ov, lat);
    checks++; if (s !== 32'd8) begin errors++; $display("[TB] FAIL midrst_followup_sum got %h expected 8", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("[TB] FAIL midrst_followup_cout got %b expected 0", co); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
